// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared accelerator constants and BIU state encoding
package acc_pkg;

  localparam int BANK_WORDS = 4096;
  localparam int BUF_WORDS  = 7 * BANK_WORDS;
  localparam int BLOCK_SIZE = 3136;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_DATA,
    ST_DRAIN,
    ST_FIN
  } biu_state_e;

endpackage

// File: rtl/imap_biu_fifo.sv
// rtl/imap_biu_fifo.sv - beat FIFO between memory read port and buffer write port
module imap_biu_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = mem_q[rptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage needs no reset; emptiness is carried entirely by the count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/imap_biu.sv
// rtl/imap_biu.sv - input-map bus interface unit: burst fetch into the 7-bank buffer
module imap_biu
  import acc_pkg::*;
#(
  parameter int BURST      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] cfg_ext_addr,
  input  logic [14:0] cfg_buf_base,
  input  logic [15:0] cfg_len,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [6:0]  mem_len,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        mem_rready,
  input  logic        imap_ren,
  output logic [31:0] imap_waddr,
  output logic [63:0] imap_wdata,
  output logic        imap_wen
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  biu_state_e  state_q;
  logic [31:0] ext_ptr_q, mem_addr_q;
  logic [15:0] rem_q;
  logic [6:0]  beats_q, mem_len_q;
  logic [14:0] wr_ptr_q, waddr_q;
  logic [63:0] wdata_q;
  logic        busy_q, done_q, err_q, err_flag_q, mem_req_q, wen_q;

  logic          fifo_full, fifo_empty, push, pop, beat_last, cfg_bad;
  logic [63:0]   fifo_head;
  logic [CW-1:0] fifo_count;
  logic [16:0]   cfg_end;
  logic [31:0]   cfg_addr;

  function automatic logic [6:0] next_len(input logic [15:0] rem);
    return (rem > 16'(BURST)) ? 7'(BURST) : rem[6:0];
  endfunction

  assign mem_rready = (state_q == ST_DATA) && !fifo_full;
  assign push       = mem_rvalid && mem_rready;
  // A MAC read this cycle suppresses the pop, so no write lands in the next cycle.
  assign pop        = !fifo_empty && !imap_ren;
  assign beat_last  = push && ((beats_q + 7'd1) == mem_len_q);
  assign cfg_end    = {2'b00, cfg_buf_base} + {1'b0, cfg_len};
  assign cfg_bad    = (cfg_len == 16'd0) || (cfg_end > 17'(BUF_WORDS));
  assign cfg_addr   = cfg_ext_addr & 32'hFFFF_FFF8;

  imap_biu_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (mem_rdata),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ext_ptr_q  <= '0;
      rem_q      <= '0;
      beats_q    <= '0;
      mem_addr_q <= '0;
      mem_len_q  <= '0;
      mem_req_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_flag_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: if (start) begin
          busy_q <= 1'b1;
          if (cfg_bad) begin
            err_flag_q <= 1'b1;
            state_q    <= ST_FIN;
          end else begin
            err_flag_q <= 1'b0;
            ext_ptr_q  <= cfg_addr;
            rem_q      <= cfg_len;
            mem_req_q  <= 1'b1;
            mem_addr_q <= cfg_addr;
            mem_len_q  <= next_len(cfg_len);
            state_q    <= ST_REQ;
          end
        end
        ST_REQ: if (mem_gnt) begin
          mem_req_q <= 1'b0;
          ext_ptr_q <= ext_ptr_q + {22'd0, mem_len_q, 3'b000};
          rem_q     <= rem_q - {9'd0, mem_len_q};
          beats_q   <= '0;
          state_q   <= ST_DATA;
        end
        ST_DATA: if (push) begin
          beats_q <= beats_q + 7'd1;
          if (beat_last) begin
            if (rem_q != 16'd0) begin
              mem_req_q  <= 1'b1;
              mem_addr_q <= ext_ptr_q;
              mem_len_q  <= next_len(rem_q);
              state_q    <= ST_REQ;
            end else begin
              state_q <= ST_DRAIN;
            end
          end
        end
        // Leave as the final pop happens so done trails the last write by one cycle.
        ST_DRAIN: if (fifo_empty || (pop && fifo_count == CW'(1))) state_q <= ST_FIN;
        ST_FIN: begin
          done_q     <= 1'b1;
          err_q      <= err_flag_q;
          err_flag_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wr_ptr_q <= '0;
    end else begin
      wen_q <= pop;
      if (pop) begin
        waddr_q <= wr_ptr_q;
        wdata_q <= fifo_head;
      end
      if (state_q == ST_IDLE && start) wr_ptr_q <= cfg_buf_base;
      else if (pop)                    wr_ptr_q <= wr_ptr_q + 15'd1;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_len    = mem_len_q;
  assign imap_wen   = wen_q;
  assign imap_waddr = {17'd0, waddr_q};
  assign imap_wdata = wdata_q;

endmodule

// File: tb/tb_imap_biu.sv
// tb/tb_imap_biu.sv - scoreboard bench for imap_biu
module tb_imap_biu;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [31:0] cfg_ext_addr = '0;
  logic [14:0] cfg_buf_base = '0;
  logic [15:0] cfg_len = '0;
  logic        busy, done, err, mem_req, mem_rready, imap_wen;
  logic [31:0] mem_addr, imap_waddr;
  logic [6:0]  mem_len;
  logic [63:0] imap_wdata;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0, imap_ren = 1'b0;
  logic [63:0] mem_rdata = '0;

  imap_biu #(.BURST(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_ext_addr(cfg_ext_addr),
    .cfg_buf_base(cfg_buf_base), .cfg_len(cfg_len), .busy(busy), .done(done), .err(err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_len(mem_len), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rready(mem_rready),
    .imap_ren(imap_ren), .imap_waddr(imap_waddr), .imap_wdata(imap_wdata), .imap_wen(imap_wen)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; logic [63:0] data; } wr_t;
  typedef struct packed { logic [31:0] addr; logic [6:0] len; } burst_t;

  wr_t    exp_wr[$];
  burst_t exp_b[$];
  int n_tests = 0, n_fail = 0;
  int cyc = 0, last_wen_cyc = -100, beats_left = 0, ren_cnt = 0;
  int beats_acc = 0, writes_seen = 0, done_cnt = 0;
  logic [31:0] beat_addr = '0;
  bit stall_en = 1'b0, prev_ren = 1'b0;

  function automatic logic [63:0] beat_data(input logic [31:0] a);
    return {a, a ^ 32'hDEAD_BEEF};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Memory model and output monitor; inputs change at negedge, handshakes judged at negedge+1.
  initial begin
    wr_t w;
    burst_t b;
    forever begin
      @(negedge clk);
      cyc++;
      mem_gnt    = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      mem_rvalid = (beats_left > 0) && (!stall_en || $urandom_range(0, 3) != 0);
      mem_rdata  = mem_rvalid ? beat_data(beat_addr) : '0;
      imap_ren   = (ren_cnt > 0);
      if (ren_cnt > 0) ren_cnt--;
      #1;
      if (imap_wen) begin
        if (prev_ren) check_eq("wen_after_ren", imap_wen, 0);
        if (exp_wr.size() == 0) check_eq("extra_write", 1, 0);
        else begin
          w = exp_wr.pop_front();
          check_eq("waddr", imap_waddr, w.addr);
          check_eq("wdata", imap_wdata, w.data);
        end
        writes_seen++;
        last_wen_cyc = cyc;
      end
      if (done) done_cnt++;
      prev_ren = imap_ren;
      if (mem_rvalid && mem_rready) begin
        beat_addr += 8;
        beats_left--;
        beats_acc++;
      end
      if (mem_req && mem_gnt) begin
        check_eq("outstanding", beats_left, 0);
        if (exp_b.size() == 0) check_eq("unexpected_burst", 1, 0);
        else begin
          b = exp_b.pop_front();
          check_eq("burst_addr", mem_addr, b.addr);
          check_eq("burst_len", mem_len, b.len);
        end
        beat_addr  = mem_addr;
        beats_left = mem_len;
      end
    end
  end

  task automatic expect_xfer(input logic [31:0] ext, input int base, input int len);
    logic [31:0] p;
    int rem, n;
    p = ext & ~32'h7;
    rem = len;
    while (rem > 0) begin
      n = (rem > 16) ? 16 : rem;
      exp_b.push_back(burst_t'{addr: p, len: 7'(n)});
      p += 32'(n * 8);
      rem -= n;
    end
    for (int i = 0; i < len; i++)
      exp_wr.push_back(wr_t'{addr: 32'(base + i), data: beat_data((ext & ~32'h7) + 32'(8 * i))});
  endtask

  task automatic pulse_start(input logic [31:0] ext, input int base, input int len);
    cfg_ext_addr = ext;
    cfg_buf_base = 15'(base);
    cfg_len      = 16'(len);
    start        = 1'b1;
  endtask

  task automatic run_xfer(input logic [31:0] ext, input int base, input int len,
                          input bit poke, input bit rblk);
    int t, wt, acc0;
    bit rej;
    rej = (len == 0) || (base + len > 28672);
    if (!rej) expect_xfer(ext, base, len);
    @(negedge clk); #2;
    pulse_start(ext, base, len);
    t = cyc;
    @(negedge clk); #2;
    start = 1'b0;
    check_eq("busy_t1", busy, 1);
    check_eq("req_t1", mem_req, !rej);
    if (poke) begin
      repeat (3) @(negedge clk);
      #2;
      pulse_start(32'h7000, 9, 3);
      @(negedge clk); #2;
      start = 1'b0;
    end
    if (rblk) begin
      acc0 = beats_acc;
      wt = 0;
      while (beats_acc - acc0 < 5 && wt < 500) begin @(negedge clk); #2; wt++; end
      ren_cnt = 10;
      repeat (10) @(negedge clk);
      #2;
      check_eq("rready_full", mem_rready, 0);
      check_eq("fifo_occupancy", beats_acc - writes_seen, 4);
    end
    wt = 0;
    while (!done && wt < 3000) begin @(negedge clk); #2; wt++; end
    check_eq("done_seen", done, 1);
    check_eq("err", err, rej);
    if (rej) check_eq("rej_latency", cyc - t, 2);
    else     check_eq("done_latency", cyc - last_wen_cyc, 1);
    check_eq("writes_left", exp_wr.size(), 0);
    check_eq("bursts_left", exp_b.size(), 0);
    @(negedge clk); #2;
    check_eq("busy_after", busy, 0);
    check_eq("done_one_cycle", done, 0);
  endtask

  initial begin
    int wt, d0, acc0;
    repeat (3) @(negedge clk);
    #2;
    check_eq("rst_ctrl", {busy, done, err, mem_req, mem_rready, imap_wen}, 0);
    check_eq("rst_mem", {mem_addr, 25'd0, mem_len}, 0);
    check_eq("rst_waddr", imap_waddr, 0);
    check_eq("rst_wdata", imap_wdata, 0);
    rst_n = 1'b1;

    run_xfer(32'h1000, 0, 40, 0, 0);
    run_xfer(32'h2000, 100, 48, 0, 1);
    run_xfer(32'h3000, 5, 0, 0, 0);
    run_xfer(32'h3000, 28600, 100, 0, 0);
    run_xfer(32'h4004, 28671, 1, 0, 0);
    stall_en = 1'b1;
    run_xfer(32'h8000, 28600, 72, 0, 0);
    run_xfer(32'h5000, 200, 20, 1, 0);
    stall_en = 1'b0;

    expect_xfer(32'h9000, 50, 40);
    @(negedge clk); #2;
    pulse_start(32'h9000, 50, 40);
    @(negedge clk); #2;
    start = 1'b0;
    acc0 = beats_acc;
    wt = 0;
    while (beats_acc - acc0 < 6 && wt < 500) begin @(negedge clk); #2; wt++; end
    rst_n = 1'b0;
    #1;
    check_eq("midrst_ctrl", {busy, done, err, mem_req, mem_rready, imap_wen}, 0);
    check_eq("midrst_mem", {mem_addr, 25'd0, mem_len}, 0);
    check_eq("midrst_wr", {imap_waddr, 32'd0} | imap_wdata, 0);
    exp_wr.delete();
    exp_b.delete();
    beats_left = 0;
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    #2;
    check_eq("no_done_on_reset", done_cnt - d0, 0);
    rst_n = 1'b1;
    run_xfer(32'h6000, 10, 33, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d failed %0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/imap_biu.md
# imap_biu

Input-feature-map bus interface unit: on a start command it fetches a run of 64-bit words from external memory in bursts and writes them linearly into the 7-bank input-map buffer over its `imap_waddr/imap_wdata/imap_wen` port. It sits directly upstream of the input-map buffer. It never writes while the MAC side is reading, because the buffer ORs read and write addresses onto shared SRAM ports. A small FIFO absorbs memory beats while writes are held off.

## Interface
- `BURST`, 16, maximum beats per memory request (power of 2, 2..64)
- `FIFO_DEPTH`, 4, beat FIFO depth (power of 2, ≥2)
- `BUF_WORDS`, 28672, buffer capacity in 64-bit words (7 banks × 4096)
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `start` in 1: one-cycle command pulse; sampled only in IDLE
- `cfg_ext_addr` in 32: external byte address of first word (8-byte aligned; bits [2:0] ignored)
- `cfg_buf_base` in 15: first buffer word address
- `cfg_len` in 16: number of 64-bit words to transfer
- `busy` out 1: high from accepted start until done
- `done` out 1: one-cycle pulse at completion
- `err` out 1: one-cycle pulse, coincident with `done`, if the config was rejected
- `mem_req` out 1: burst request valid
- `mem_addr` out 32: burst byte address
- `mem_len` out 7: beats in the burst (1..BURST)
- `mem_gnt` in 1: request accepted when `mem_req & mem_gnt`
- `mem_rvalid` in 1: read beat valid
- `mem_rdata` in 64: read beat data
- `mem_rready` out 1: beat accepted when `mem_rvalid & mem_rready`
- `imap_ren` in 1: MAC-side read active this cycle; writes are blocked
- `imap_waddr` out 32: buffer write word address (upper bits zero)
- `imap_wdata` out 64: buffer write data
- `imap_wen` out 1: buffer write strobe

## Operation
- FSM states: IDLE, REQ, DATA, DRAIN, FIN.
- **IDLE**
  - On `start`, latch the config and raise `busy`.
  - If `cfg_len==0`, or `cfg_buf_base+cfg_len > BUF_WORDS` (17-bit compare), go to FIN with `err=1`.
  - Otherwise go to REQ.
- **REQ**
  - Drive `mem_req`, `mem_addr=ext_ptr`, and `mem_len=min(BURST, remaining_req)`.
  - On grant: `ext_ptr += mem_len*8` and `remaining_req -= mem_len`; go to DATA.
- **DATA**
  - `mem_rready = !fifo_full`; each accepted beat is pushed to the FIFO.
  - After `mem_len` beats: if `remaining_req>0` go to REQ, else go to DRAIN.
  - Only one burst is outstanding at a time.
- **DRAIN**: wait until the FIFO is empty and the last write is issued, then go to FIN.
- **FIN**: pulse `done` (and `err` if flagged), drop `busy`, go to IDLE.
- **Write side** (independent of FSM state)
  - Every cycle with the FIFO non-empty and `imap_ren==0`: pop, register `imap_wen=1`, `imap_wdata=head`, `imap_waddr=wr_ptr`, then `wr_ptr++`.
  - `wr_ptr` is initialised to `cfg_buf_base` on start.
- FIFO push and pop in the same cycle are allowed; the count is unchanged.
- A `start` outside IDLE is ignored; config is not re-latched.
- Reset mid-transfer aborts everything immediately. The FIFO is emptied, and no `done` is produced.

## Timing
- Reset values: `busy`, `done`, `err`, `mem_req`, `mem_rready`, `imap_wen` = 0; `mem_addr`, `mem_len`, `imap_waddr`, `imap_wdata` = 0.
- `start` at cycle t: `busy` and `mem_req` are high at t+1.
- A beat accepted at cycle t is eligible to pop at t+1, giving `imap_wen` at t+2 when `imap_ren` is low.
- `imap_ren` high at cycle t means `imap_wen` is low at t+1. The write path is registered, so the buffer sees no write in any cycle following a read request.
- `mem_addr` and `mem_len` stay stable while `mem_req` is high and not yet granted.
- `done` is asserted one cycle after the final `imap_wen` pulse. For a rejected config, `done` and `err` assert at t+2.
- Full throughput is one word per cycle with `imap_ren` low and no memory stalls.

## Structure
- Shared package `acc_pkg`: `BUF_WORDS`, `BLOCK_SIZE` (3136), `BANK_WORDS` (4096), and the FSM state encoding.
- Sub-module `imap_biu_fifo`: synchronous FIFO of width 64 and depth `FIFO_DEPTH`, with `full`/`empty` and asynchronous reset.

## Test plan
- **Basic transfer**: `cfg_len=40`, `BURST=16`, `base=0`, `ext=0x1000`, no stalls → bursts (0x1000,16), (0x1080,16), (0x1100,8); 40 writes to addresses 0..39 with matching data; `done` one cycle after write 39.
- **Read blocking**: hold `imap_ren=1` for 10 cycles mid-transfer → no `imap_wen` in the cycle after any `imap_ren`; `mem_rready` drops once 4 beats are queued; no data is lost or reordered.
- **Rejected config**: `cfg_len=0` → `done=err=1` at t+2 with no `mem_req`. `base=28600`, `len=100` → also rejected.
- **Full-capacity boundary**: `base=28671`, `len=1` → a single write at 28671, with no `err`.
- **Ignored start**: `start` pulsed while busy → ignored; the transfer completes with the original config.
- **Reset mid-transfer**: assert `rst_n=0` mid-DATA → all outputs 0 at once; a new start afterwards transfers correctly.
